// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite single-transaction master.
package axi4lite_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 6;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RESP
    } state_e;

endpackage

// File: rtl/axi4lite_master_ctrl.sv
// Command-to-AXI4-Lite master, one transaction in flight, all outputs registered.
// Optional response timeout: define AXI4LITE_MASTER_TIMEOUT_EN.
module axi4lite_master_ctrl
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  rready_q, rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        cnt_d  = '0;
        drop_d = drop_q;
        // A late response to a timed-out transfer is swallowed here
        if (drop_q && ((m_axi_bvalid && bready_q) ||
                       (m_axi_rvalid && rready_q))) begin
            drop_d   = 1'b0;
            bready_d = 1'b0;
            rready_d = 1'b0;
            if (state_q == IDLE) cmd_ready_d = 1'b1;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_we) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (m_axi_awready) awvalid_d = 1'b0;
                if (m_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (m_axi_bresp != AXI_RESP_OKAY);
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    drop_d      = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RD_REQ: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    state_d     = RESP;
                end
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    drop_d      = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
                    cmd_ready_d = !drop_d;
`else
                    cmd_ready_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_ctrl.sv
// Directed bench for axi4lite_master_ctrl; timeout case runs only
// when AXI4LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi4lite_master_ctrl;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    bresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi4lite_master_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .m_axi_aclk(clk),
        .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we(cmd_we),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .m_axi_awaddr(awaddr),
        .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata),
        .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_araddr(araddr),
        .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata),
        .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
        check("send_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
        arready = 0; rvalid = 0; rdata = '0;
        repeat (2) tick();

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0);
        check("rst_readies", {bready, rready}, 2'b0);
        check("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
        check("rst_addr_data", {awaddr, araddr, wdata}, 44'h0);
        rst_n = 1'b1;
        tick();

        // Write 0x0C <- DEADBEEF, both readies one cycle after valids
        send(1'b1, 6'h0C, 32'hDEADBEEF);
        check("wr_valids", {awvalid, wvalid}, 2'b11);
        check("wr_awaddr", awaddr, 6'h0C);
        check("wr_wdata", wdata, 32'hDEADBEEF);
        check("wr_busy", cmd_ready, 0);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        check("wr_valids_drop", {awvalid, wvalid}, 2'b00);
        check("wr_bready", bready, 1);
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_bready_drop", bready, 0);
        tick();
        check("wr_done", {rsp_valid, cmd_ready}, 2'b01);

        // Read back 0x0C
        send(1'b0, 6'h0C, '0);
        check("rd_arvalid", arvalid, 1);
        check("rd_araddr", araddr, 6'h0C);
        arready = 1;
        tick();
        arready = 0;
        check("rd_ar_drop", {arvalid, rready}, 2'b01);
        tick();
        check("rd_wait", {rready, rsp_valid}, 2'b10);
        rvalid = 1; rdata = 32'hDEADBEEF;
        tick();
        rvalid = 0;
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_rready_drop", rready, 0);
        tick();
        check("rd_done", {rsp_valid, cmd_ready}, 2'b01);

        // W accepted three cycles before AW
        send(1'b1, 6'h10, 32'h12345678);
        wready = 1;
        tick();
        wready = 0;
        check("split_w_drop", {awvalid, wvalid}, 2'b10);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("split_aw_hold", {awvalid, wvalid, bready}, 3'b100);
            check("split_awaddr", awaddr, 6'h10);
        end
        awready = 1;
        tick();
        awready = 0;
        check("split_aw_drop", {awvalid, bready}, 2'b01);
        bvalid = 1;
        tick();
        check("split_rsp", {rsp_valid, bready}, 2'b10);
        tick();
        check("split_stray_b", {bready, rsp_valid, cmd_ready}, 3'b001);
        tick();
        check("split_one_b", {bready, rsp_valid}, 2'b00);
        bvalid = 0;

        // SLVERR with consumer stalled five cycles
        rsp_ready = 0;
        send(1'b1, 6'h04, 32'hCAFEF00D);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        bvalid = 1; bresp = 2'b10;
        tick();
        bvalid = 0; bresp = 2'b00;
        check("err_rsp", {rsp_valid, rsp_err}, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("err_hold", {rsp_valid, rsp_err, cmd_ready}, 3'b110);
            check("err_rdata", rsp_rdata, 0);
        end
        rsp_ready = 1;
        tick();
        check("err_done", {rsp_valid, cmd_ready}, 2'b01);

        // Reset while waiting for read data
        send(1'b0, 6'h08, '0);
        arready = 1;
        tick();
        arready = 0;
        check("rst_mid_rready", rready, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outs",
              {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
        check("rst_async_cmd_ready", cmd_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_rel_idle", {cmd_ready, rsp_valid, rready}, 3'b100);
        tick();
        check("rst_no_rsp", rsp_valid, 0);

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
        // Slave never answers; late rvalid must be swallowed
        send(1'b0, 6'h20, '0);
        arready = 1;
        tick();
        arready = 0;
        repeat (7) tick();
        check("to_not_yet", rsp_valid, 0);
        tick();
        check("to_rsp", {rsp_valid, rsp_err}, 2'b11);
        check("to_rdata", rsp_rdata, 0);
        tick();
        check("to_drop_wait", {rsp_valid, cmd_ready, rready}, 3'b001);
        rvalid = 1; rdata = 32'h0000AAAA;
        tick();
        rvalid = 0;
        check("to_absorbed", {rsp_valid, cmd_ready, rready}, 3'b010);
        send(1'b0, 6'h24, '0);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h00005555;
        tick();
        rvalid = 0;
        check("to_next_rsp", {rsp_valid, rsp_err}, 2'b10);
        check("to_next_rdata", rsp_rdata, 32'h00005555);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
